// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline sequencer.
//   hz_state_e : sequencer FSM state (RUN, MEM_WAIT, ERR)
//   fwd_sel_e  : operand forwarding select encoding
//   REG_ADDR_W : register-file address width
//   rd_hits_rs : true when a producing stage's rd feeds the given rs
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // x0 is hardwired to zero, so a write to it never produces a usable value.
    function automatic logic rd_hits_rs(input logic                  wren,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] rs);
        return wren && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding select for one ALU operand.
//   rs_addr      in  source register of the ID instruction
//   mem_rd_addr  in  rd of the instruction in MEM
//   mem_rd_wren  in  MEM instruction writes rd
//   wb_rd_addr   in  rd of the instruction in WB
//   wb_rd_wren   in  WB instruction writes rd
//   fwd_sel      out FWD_RF / FWD_EXMEM / FWD_MEMWB
module hazard_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_wren,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_wren,
    output fwd_sel_e              fwd_sel
);

    // NOTE: a default assignment before any branch keeps always_comb free of latches.
    always_comb begin
        fwd_sel = FWD_RF;
        // The younger producer (MEM) holds the newest value, so it wins over WB.
        if (rd_hits_rs(mem_rd_wren, mem_rd_addr, rs_addr)) begin
            fwd_sel = FWD_EXMEM;
        end else if (rd_hits_rs(wb_rd_wren, wb_rd_addr, rs_addr)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core.
// Produces pipeline register enables, bubble flushes and forwarding selects,
// handles load-use stalls, taken branch/JAL flushes and the LSU req/ack
// handshake with a wait timeout that latches a sticky error.
//   clk, rst                       clock, synchronous active-high reset
//   id_rs1_addr, id_rs2_addr       source registers of the ID instruction
//   ex_rd_addr/_wren/_is_load      destination info of the EX instruction
//   ex_pc_sel                      branch/JAL resolved taken in EX
//   mem_rd_addr/_wren, mem_is_mem  destination info of MEM, LSU access flag
//   wb_rd_addr/_wren               destination info of WB
//   lsu_ack / lsu_req              LSU handshake
//   pc_en .. mem_wb_en             pipeline register enables
//   if_id_flush, id_ex_flush       turn the register contents into a bubble
//   fwd_a_sel, fwd_b_sel           operand forwarding selects
//   mem_err                        sticky LSU timeout flag
//   stall_cnt                      saturating count of cycles with pc_en=0
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_wren,
    input  logic                  ex_is_load,
    input  logic                  ex_pc_sel,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_wren,
    input  logic                  mem_is_mem,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_wren,
    input  logic                  lsu_ack,
    output logic                  lsu_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic     mem_freeze;
    logic     load_use;
    fwd_sel_e fwd_a_raw, fwd_b_raw;

    // ---------------- forwarding ----------------
    hazard_fwd_unit u_fwd_a (
        .rs_addr     (id_rs1_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_wren (mem_rd_wren),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_wren  (wb_rd_wren),
        .fwd_sel     (fwd_a_raw)
    );

    hazard_fwd_unit u_fwd_b (
        .rs_addr     (id_rs2_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_wren (mem_rd_wren),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_wren  (wb_rd_wren),
        .fwd_sel     (fwd_b_raw)
    );

    assign fwd_a_sel = rst ? 2'b00 : fwd_a_raw;
    assign fwd_b_sel = rst ? 2'b00 : fwd_b_raw;

    // ---------------- hazard detection ----------------
    // Both rs fields are compared even if the instruction does not read one;
    // the occasional extra bubble is cheaper than decoding operand usage here.
    assign load_use = ex_is_load && ex_rd_wren && (ex_rd_addr != '0) &&
                      ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

    // The request stays up until ack; in ERR the LSU is abandoned.
    assign lsu_req    = !rst && mem_is_mem && (state_q != ERR);
    assign mem_freeze = (lsu_req && !lsu_ack) || (state_q == ERR);

    // A taken branch seen while frozen is not lost: EX is held, so ex_pc_sel
    // is still asserted on the first unfrozen cycle and the flush fires then.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_freeze) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        end else if (ex_pc_sel) begin
            // The wrong-path instructions in IF/ID and ID/EX are discarded,
            // which also removes any load-use consumer.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_is_mem && !lsu_ack) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (lsu_ack)                       state_d = RUN;
                else if (wait_cnt_q == WAIT_LAST)  state_d = ERR;
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase

        wait_cnt_d = '0;
        if (state_q == MEM_WAIT && state_d == MEM_WAIT) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        mem_err_d = mem_err_q || (state_d == ERR);

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. MEM_TIMEOUT is shrunk to 4 so
// the timeout is reachable, and CNT_W to 4 so stall_cnt saturation (15) is too.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic       ex_rd_wren, ex_is_load, ex_pc_sel, mem_rd_wren, mem_is_mem;
    logic       wb_rd_wren, lsu_ack;
    logic       lsu_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_err;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [4:0] en;
    logic [1:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_ex_flush};

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rd_wren  (ex_rd_wren),
        .ex_is_load  (ex_is_load),
        .ex_pc_sel   (ex_pc_sel),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_wren (mem_rd_wren),
        .mem_is_mem  (mem_is_mem),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_wren  (wb_rd_wren),
        .lsu_ack     (lsu_ack),
        .lsu_req     (lsu_req),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0;
        ex_rd_addr  = '0; ex_rd_wren  = 1'b0; ex_is_load = 1'b0; ex_pc_sel = 1'b0;
        mem_rd_addr = '0; mem_rd_wren = 1'b0; mem_is_mem = 1'b0;
        wb_rd_addr  = '0; wb_rd_wren  = 1'b0; lsu_ack    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // ---- reset: outputs forced even with hazards and LSU traffic present
        tick();
        mem_rd_addr = 5'd7; mem_rd_wren = 1'b1; id_rs1_addr = 5'd7; mem_is_mem = 1'b1;
        settle();
        check("rst_en",      en, 5'b00000);
        check("rst_flush",   fl, 2'b11);
        check("rst_lsu_req", lsu_req, 1'b0);
        check("rst_fwd_a",   fwd_a_sel, 2'd0);
        tick();
        check("rst_stall_cnt", stall_cnt, 4'd0);
        check("rst_mem_err",   mem_err, 1'b0);
        idle_inputs();
        rst = 1'b0;
        settle();
        check("run_en",    en, 5'b11111);
        check("run_flush", fl, 2'b00);

        // ---- 1. load-use on rs1: exactly one bubble
        ex_is_load = 1'b1; ex_rd_wren = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
        settle();
        check("lu_en",    en, 5'b00111);
        check("lu_flush", fl, 2'b01);
        tick();
        ex_is_load = 1'b0; ex_rd_wren = 1'b0; ex_rd_addr = '0;
        settle();
        check("lu_after_en",  en, 5'b11111);
        check("lu_stall_cnt", stall_cnt, 4'd1);
        // load to x0 never stalls
        ex_is_load = 1'b1; ex_rd_wren = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
        settle();
        check("lu_x0_en", en, 5'b11111);

        // ---- 2. taken branch beats load-use (rs2 match)
        ex_rd_addr = 5'd9; id_rs2_addr = 5'd9; ex_pc_sel = 1'b1;
        settle();
        check("br_lu_en",    en, 5'b11111);
        check("br_lu_flush", fl, 2'b11);
        tick();
        idle_inputs();
        settle();
        check("br_stall_cnt", stall_cnt, 4'd1);

        // ---- 3. LSU ack after 3 frozen cycles
        mem_is_mem = 1'b1;
        settle();
        check("lsu_c1_req", lsu_req, 1'b1);
        check("lsu_c1_en",  en, 5'b00000);
        check("lsu_c1_fl",  fl, 2'b00);
        tick();
        settle();
        check("lsu_c2_req", lsu_req, 1'b1);
        check("lsu_c2_en",  en, 5'b00000);
        tick();
        settle();
        check("lsu_c3_en",  en, 5'b00000);
        tick();
        lsu_ack = 1'b1;
        settle();
        check("lsu_ack_req", lsu_req, 1'b1);
        check("lsu_ack_en",  en, 5'b11111);
        tick();
        // back in RUN: a zero-wait access does not stall
        settle();
        check("lsu_stall_cnt", stall_cnt, 4'd4);
        check("zw_en",         en, 5'b11111);
        tick();
        idle_inputs();
        settle();
        check("zw_stall_cnt", stall_cnt, 4'd4);

        // ---- 6. taken branch during a freeze is deferred to the first unfrozen cycle
        mem_is_mem = 1'b1; ex_pc_sel = 1'b1;
        settle();
        check("dfr_c1_fl", fl, 2'b00);
        tick();
        settle();
        check("dfr_c2_fl", fl, 2'b00);
        check("dfr_c2_en", en, 5'b00000);
        tick();
        lsu_ack = 1'b1;
        settle();
        check("dfr_ack_fl", fl, 2'b11);
        check("dfr_ack_en", en, 5'b11111);
        tick();
        idle_inputs();
        settle();
        check("dfr_stall_cnt", stall_cnt, 4'd6);

        // ---- 5. forwarding
        mem_rd_addr = 5'd7; mem_rd_wren = 1'b1; wb_rd_addr = 5'd7; wb_rd_wren = 1'b1;
        id_rs2_addr = 5'd7;
        settle();
        check("fwd_b_exmem", fwd_b_sel, 2'd1);
        check("fwd_a_none",  fwd_a_sel, 2'd0);
        mem_rd_wren = 1'b0;
        settle();
        check("fwd_b_memwb", fwd_b_sel, 2'd2);
        mem_rd_addr = 5'd3; mem_rd_wren = 1'b1; id_rs1_addr = 5'd3;
        settle();
        check("fwd_a_exmem", fwd_a_sel, 2'd1);
        mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        settle();
        check("fwd_a_x0", fwd_a_sel, 2'd0);
        check("fwd_b_x0", fwd_b_sel, 2'd0);
        tick();
        idle_inputs();

        // ---- 4. timeout: 1 RUN freeze + 4 MEM_WAIT cycles, then ERR
        mem_is_mem = 1'b1;
        tick(); tick(); tick(); tick();
        settle();
        check("to_last_wait_req", lsu_req, 1'b1);
        check("to_last_wait_err", mem_err, 1'b0);
        tick();
        settle();
        check("err_mem_err",   mem_err, 1'b1);
        check("err_lsu_req",   lsu_req, 1'b0);
        check("err_stall_cnt", stall_cnt, 4'd11);
        // ERR is terminal: ack and a taken branch change nothing
        lsu_ack = 1'b1; ex_pc_sel = 1'b1;
        settle();
        check("err_en", en, 5'b00000);
        check("err_fl", fl, 2'b00);
        tick(); tick(); tick(); tick();
        settle();
        check("sat_stall_cnt", stall_cnt, 4'd15);
        check("err_hold_en",   en, 5'b00000);
        tick();
        settle();
        check("sat_hold_stall_cnt", stall_cnt, 4'd15);
        rst = 1'b1;
        settle();
        check("err_rst_req", lsu_req, 1'b0);
        check("err_rst_fl",  fl, 2'b11);
        tick();
        check("err_rst_mem_err",   mem_err, 1'b0);
        check("err_rst_stall_cnt", stall_cnt, 4'd0);

        // ---- reset in the middle of a wait aborts the request at once
        idle_inputs();
        rst = 1'b0;
        mem_is_mem = 1'b1;
        tick(); tick();
        rst = 1'b1;
        settle();
        check("midwait_rst_req", lsu_req, 1'b0);
        tick();
        check("midwait_rst_err", mem_err, 1'b0);
        rst = 1'b0;
        // ack on the last allowed wait cycle still completes normally
        tick(); tick(); tick(); tick();
        lsu_ack = 1'b1;
        settle();
        check("last_ack_en", en, 5'b11111);
        tick();
        idle_inputs();
        settle();
        check("last_ack_err", mem_err, 1'b0);
        check("last_ack_run", en, 5'b11111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
